// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared constants and FSM encoding for the data cache
package data_cache_pkg;

   localparam int WORD_SIZE      = 16;
   localparam int ADDR_SIZE      = 16;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_NUM_LINES  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU data port and single-word memory port of the data cache
interface data_cache_if;
   import data_cache_pkg::*;

   logic                 cpu_read;
   logic                 cpu_write;
   logic [ADDR_SIZE-1:0] cpu_addr;
   logic [WORD_SIZE-1:0] cpu_wdata;
   logic [WORD_SIZE-1:0] cpu_rdata;
   logic                 cpu_stall;

   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [WORD_SIZE-1:0] mem_rdata;
   logic                 mem_ready;

   // Environment side: drives CPU requests and memory responses.
   modport master (
      output cpu_read, cpu_write, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );

   // Cache side.
   modport slave (
      input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

endinterface

// File: rtl/data_cache_array.sv
// rtl/data_cache_array.sv - tag/valid/data storage, index-addressed read, one write port
module cache_array
   import data_cache_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int NUM_LINES  = DEF_NUM_LINES,
   parameter int TAG_W      = 12
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [$clog2(NUM_LINES)-1:0]  rd_index,
   input  logic [$clog2(LINE_WORDS)-1:0] rd_offset,
   output logic                          rd_valid,
   output logic [TAG_W-1:0]              rd_tag,
   output logic [WORD_SIZE-1:0]          rd_word,
   input  logic [$clog2(NUM_LINES)-1:0]  wr_index,
   input  logic [LINE_WORDS-1:0]         wr_word_en,
   input  logic [WORD_SIZE-1:0]          wr_data,
   input  logic                          wr_meta_en,
   input  logic                          wr_valid,
   input  logic [TAG_W-1:0]              wr_tag
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [WORD_SIZE-1:0] data_q [NUM_LINES][LINE_WORDS];

   // Valid bits are the only storage cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset_n)
         valid_q <= '0;
      else if (wr_meta_en)
         valid_q[wr_index] <= wr_valid;
   end

   // Tag and per-word data writes; contents are meaningless until valid is set.
   always_ff @(posedge clk) begin
      if (wr_meta_en)
         tag_q[wr_index] <= wr_tag;
      for (int w = 0; w < LINE_WORDS; w++)
         if (wr_word_en[w])
            data_q[wr_index][w] <= wr_data;
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through, no-write-allocate data cache
module data_cache
   import data_cache_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int NUM_LINES  = DEF_NUM_LINES
) (
   input  logic        clk,
   input  logic        reset_n,
   data_cache_if.slave bus,
   output logic [15:0] num_hit,
   output logic [15:0] num_miss
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_SIZE - IDX_W - OFF_W;

   logic [TAG_W-1:0]     cpu_tag;
   logic [IDX_W-1:0]     cpu_index;
   logic [OFF_W-1:0]     cpu_offset;
   logic                 rd_valid;
   logic [TAG_W-1:0]     rd_tag;
   logic [WORD_SIZE-1:0] rd_word;
   logic [LINE_WORDS-1:0] wr_word_en;
   logic [WORD_SIZE-1:0] wr_data;
   logic                 wr_meta_en;
   logic                 wr_valid;
   logic                 lookup_hit;
   logic                 is_read;
   logic                 is_write;
   logic                 mem_done;

   state_t               state;
   logic [OFF_W-1:0]     fill_cnt;
   logic [OFF_W-1:0]     fill_next;
   logic                 mem_req_q;
   logic                 mem_we_q;
   logic [ADDR_SIZE-1:0] mem_addr_q;
   logic [WORD_SIZE-1:0] mem_wdata_q;

   assign cpu_tag    = bus.cpu_addr[ADDR_SIZE-1 -: TAG_W];
   assign cpu_index  = bus.cpu_addr[OFF_W +: IDX_W];
   assign cpu_offset = bus.cpu_addr[OFF_W-1:0];

   // A simultaneous read and write is handled as a write.
   assign is_write   = bus.cpu_write;
   assign is_read    = bus.cpu_read & ~bus.cpu_write;
   assign lookup_hit = rd_valid && (rd_tag == cpu_tag);
   // A ready pulse only counts while a request is actually outstanding.
   assign mem_done   = bus.mem_ready & mem_req_q;
   assign fill_next  = fill_cnt + OFF_W'(1);

   cache_array #(
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES),
      .TAG_W      (TAG_W)
   ) u_array (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_index   (cpu_index),
      .rd_offset  (cpu_offset),
      .rd_valid   (rd_valid),
      .rd_tag     (rd_tag),
      .rd_word    (rd_word),
      .wr_index   (cpu_index),
      .wr_word_en (wr_word_en),
      .wr_data    (wr_data),
      .wr_meta_en (wr_meta_en),
      .wr_valid   (wr_valid),
      .wr_tag     (cpu_tag)
   );

   // Stall and array writes are combinational so hits and write completion are same-cycle.
   always_comb begin
      bus.cpu_stall = 1'b0;
      wr_word_en    = '0;
      wr_data       = bus.mem_rdata;
      wr_meta_en    = 1'b0;
      wr_valid      = 1'b0;
      case (state)
         IDLE: begin
            bus.cpu_stall = is_write | (is_read & ~lookup_hit);
            // Invalidate before refilling so an abandoned fill never looks valid.
            if (is_read && !lookup_hit)
               wr_meta_en = 1'b1;
         end
         FILL: begin
            bus.cpu_stall = 1'b1;
            if (mem_done) begin
               wr_word_en = LINE_WORDS'(1) << fill_cnt;
               if (&fill_cnt) begin
                  wr_meta_en = 1'b1;
                  wr_valid   = 1'b1;
               end
            end
         end
         WRITE: begin
            bus.cpu_stall = ~mem_done;
            wr_data       = bus.cpu_wdata;
            if (mem_done && lookup_hit)
               wr_word_en = LINE_WORDS'(1) << cpu_offset;
         end
         default: bus.cpu_stall = 1'b0;
      endcase
   end

   // Controller: state, fill counter, registered memory request and hit/miss counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         fill_cnt    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         num_hit     <= '0;
         num_miss    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (is_write) begin
                  if (lookup_hit) num_hit  <= num_hit + 16'd1;
                  else            num_miss <= num_miss + 16'd1;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= bus.cpu_addr;
                  mem_wdata_q <= bus.cpu_wdata;
                  state       <= WRITE;
               end else if (is_read) begin
                  if (lookup_hit) begin
                     num_hit <= num_hit + 16'd1;
                  end else begin
                     num_miss   <= num_miss + 16'd1;
                     fill_cnt   <= '0;
                     mem_req_q  <= 1'b1;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= {cpu_tag, cpu_index, {OFF_W{1'b0}}};
                     state      <= FILL;
                  end
               end
            end
            FILL: begin
               if (mem_done) begin
                  fill_cnt   <= fill_next;
                  mem_addr_q <= {mem_addr_q[ADDR_SIZE-1:OFF_W], fill_next};
                  if (&fill_cnt) begin
                     mem_req_q <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            WRITE: begin
               if (mem_done) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cpu_rdata = rd_word;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed table plus randomized accesses against a cache reference model
module tb_data_cache;
   import data_cache_pkg::*;

   typedef struct {
      logic        we;
      logic [15:0] addr;
   } op_t;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      bit          chk_rdata;
      int          exp_stalls;
      int          exp_ops;
      logic [15:0] exp_op_addr;
      bit          exp_we;
      int          exp_hit;
      int          exp_miss;
   } vec_t;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] num_hit;
   logic [15:0] num_miss;

   data_cache_if bus ();

   data_cache #(.LINE_WORDS(4), .NUM_LINES(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .num_hit  (num_hit),
      .num_miss (num_miss)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [15:0] mem [0:65535];
   int          mem_lat    = 2;
   bit          stray      = 1'b0;
   int          req_cycles = 0;
   op_t         ops [$];

   function automatic logic [15:0] memval(input logic [15:0] a);
      return 16'((32'(a) * 32'd40503) ^ 32'h1F2E);
   endfunction

   function automatic vec_t mk(input bit rd, input bit wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_rdata,
                               input bit chk, input int stalls, input int nops,
                               input logic [15:0] op_addr, input bit we,
                               input int hit, input int miss);
      return '{rd, wr, addr, wdata, exp_rdata, chk, stalls, nops, op_addr, we, hit, miss};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Memory: a request is answered after mem_lat waiting cycles, ready lasts one cycle.
   initial begin
      int lat_cnt;
      lat_cnt       = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      for (int a = 0; a < 65536; a++) mem[a] = memval(16'(a));
      forever begin
         @(negedge clk);
         if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            lat_cnt       = 0;
         end
         if (bus.mem_req) begin
            req_cycles++;
            if (lat_cnt == mem_lat) begin
               bus.mem_ready = 1'b1;
               if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
               else            bus.mem_rdata     = mem[bus.mem_addr];
               ops.push_back('{we: bus.mem_we, addr: bus.mem_addr});
            end else begin
               lat_cnt++;
            end
         end else begin
            lat_cnt = 0;
            if (stray) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = 16'hDEAD;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, output logic [15:0] rdata,
                         output int stalls, output bit done);
      @(negedge clk);
      bus.cpu_read  = rd;
      bus.cpu_write = wr;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      stalls = 0;
      done   = 1'b0;
      rdata  = '0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (!bus.cpu_stall) begin
            done  = 1'b1;
            rdata = bus.cpu_rdata;
            break;
         end
         stalls++;
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int          n0;
      int          stalls;
      logic [15:0] rd;
      bit          done;
      n0 = ops.size();
      access(v.rd, v.wr, v.addr, v.wdata, rd, stalls, done);
      check($sformatf("%s.done", tag), 32'(done), 1);
      if (done) begin
         if (v.chk_rdata) check($sformatf("%s.rdata", tag), 32'(rd), 32'(v.exp_rdata));
         check($sformatf("%s.stalls", tag), stalls, v.exp_stalls);
      end
      @(negedge clk);
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      #1;
      check($sformatf("%s.nops", tag), ops.size() - n0, v.exp_ops);
      for (int k = 0; k < v.exp_ops; k++) begin
         if (n0 + k < ops.size()) begin
            check($sformatf("%s.op%0d.addr", tag, k), 32'(ops[n0+k].addr), 32'(v.exp_op_addr + 16'(k)));
            check($sformatf("%s.op%0d.we", tag, k), 32'(ops[n0+k].we), 32'(v.exp_we));
         end
      end
      check($sformatf("%s.num_hit", tag), 32'(num_hit), v.exp_hit);
      check($sformatf("%s.num_miss", tag), 32'(num_miss), v.exp_miss);
   endtask

   initial begin
      vec_t        vt [10];
      vec_t        v;
      bit          mvalid [4];
      logic [11:0] mtag [4];
      int          m_hit;
      int          m_miss;
      int          rc0;
      int          op;
      logic [15:0] a;
      logic [15:0] wd;
      logic [1:0]  idx;
      bit          hit;

      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;

      // Memory latency 2: a miss stalls 1 lookup cycle + 4 words x 3 cycles, a write 1 + 2.
      vt[0] = mk(1, 0, 16'h0012, 0, memval(16'h0012), 1, 13, 4, 16'h0010, 0, 1, 1);
      vt[1] = mk(1, 0, 16'h0013, 0, memval(16'h0013), 1,  0, 0, 16'h0000, 0, 2, 1);
      vt[2] = mk(0, 1, 16'h0011, 16'hBEEF, 0,         0,  3, 1, 16'h0011, 1, 3, 1);
      vt[3] = mk(1, 0, 16'h0011, 0, 16'hBEEF,         1,  0, 0, 16'h0000, 0, 4, 1);
      vt[4] = mk(0, 1, 16'h0051, 16'h1234, 0,         0,  3, 1, 16'h0051, 1, 4, 2);
      vt[5] = mk(1, 0, 16'h0011, 0, 16'hBEEF,         1,  0, 0, 16'h0000, 0, 5, 2);
      vt[6] = mk(1, 0, 16'h0051, 0, 16'h1234,         1, 13, 4, 16'h0050, 0, 6, 3);
      vt[7] = mk(1, 0, 16'h0011, 0, 16'hBEEF,         1, 13, 4, 16'h0010, 0, 7, 4);
      vt[8] = mk(1, 1, 16'h0030, 16'h7777, 0,         0,  3, 1, 16'h0030, 1, 7, 5);
      vt[9] = mk(1, 0, 16'h0030, 0, 16'h7777,         1, 13, 4, 16'h0030, 0, 8, 6);

      repeat (3) @(negedge clk);
      #1;
      check("reset.num_hit", 32'(num_hit), 0);
      check("reset.num_miss", 32'(num_miss), 0);
      check("reset.mem_req", 32'(bus.mem_req), 0);
      check("reset.mem_we", 32'(bus.mem_we), 0);
      check("reset.cpu_stall", 32'(bus.cpu_stall), 0);
      @(negedge clk);
      reset_n = 1'b1;

      rc0 = req_cycles;
      run_vec(vt[0], "v0");
      check("v0.req_cycles", req_cycles - rc0, 12);
      for (int i = 1; i < 10; i++) run_vec(vt[i], $sformatf("v%0d", i));

      // Ready pulse with no request outstanding must leave the cache idle.
      @(posedge clk);
      #1 stray = 1'b1;
      @(posedge clk);
      #1 stray = 1'b0;
      @(negedge clk);
      #1;
      check("stray.num_hit", 32'(num_hit), 8);
      check("stray.num_miss", 32'(num_miss), 6);
      check("stray.mem_req", 32'(bus.mem_req), 0);
      check("stray.cpu_stall", 32'(bus.cpu_stall), 0);
      run_vec(mk(1, 0, 16'h0030, 0, 16'h7777, 1, 0, 0, 16'h0000, 0, 9, 6), "stray.hit");

      // Reset in the middle of a line fill.
      @(negedge clk);
      bus.cpu_read = 1'b1;
      bus.cpu_addr = 16'h0020;
      repeat (5) @(negedge clk);
      #1;
      check("rst.in_fill", 32'(bus.mem_req), 1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst.mem_req", 32'(bus.mem_req), 0);
      check("rst.num_miss", 32'(num_miss), 0);
      @(negedge clk);
      reset_n      = 1'b1;
      bus.cpu_read = 1'b0;
      run_vec(mk(1, 0, 16'h0020, 0, memval(16'h0020), 1, 13, 4, 16'h0020, 0, 1, 1), "rst.refill");

      // Randomized accesses against a resident-tag model; memory holds the true data.
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mvalid[i] = 1'b0;
         mtag[i]   = '0;
      end
      m_hit  = 0;
      m_miss = 0;
      for (int n = 0; n < 200; n++) begin
         mem_lat = $urandom_range(0, 3);
         a       = 16'($urandom_range(0, 127));
         op      = $urandom_range(0, 2);
         idx     = a[3:2];
         hit     = mvalid[idx] && (mtag[idx] == a[15:4]);
         if (op != 0) begin
            if (hit) m_hit++;
            else     m_miss++;
            wd = 16'($urandom);
            v  = mk(op == 2, 1, a, wd, 0, 0, 1 + mem_lat, 1, a, 1, m_hit, m_miss);
         end else if (hit) begin
            m_hit++;
            v = mk(1, 0, a, 0, mem[a], 1, 0, 0, a, 0, m_hit, m_miss);
         end else begin
            m_miss++;
            m_hit++;
            mvalid[idx] = 1'b1;
            mtag[idx]   = a[15:4];
            v = mk(1, 0, a, 0, mem[a], 1, 1 + 4 * (mem_lat + 1), 4, {a[15:2], 2'b00}, 0, m_hit, m_miss);
         end
         run_vec(v, $sformatf("r%0d", n));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
